// File: rtl/fetch_ctrl.sv
// Instruction fetch/sequence controller: fetches one 16-bit word per instruction,
// executes PC control flow in a single EXEC cycle, and parks in HALT until reset.
module fetch_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        zero_flag,
    output logic [15:0] inst,
    output logic        reg_en,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [15:0] r_inst;

    state_t      w_state_nxt;
    logic [7:0]  w_pc_nxt;
    logic [15:0] w_inst_nxt;
    logic [3:0]  w_opcode;
    logic [7:0]  w_imm;
    logic [7:0]  w_pc_inc;
    logic        w_write_class;

    assign w_opcode      = r_inst[15:12];
    assign w_imm         = r_inst[7:0];
    assign w_pc_inc      = r_pc + 8'd1;
    assign w_write_class = (w_opcode >= 4'h1) && (w_opcode <= 4'h7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        imem_req    = 1'b0;
        reg_en      = 1'b0;
        halted      = 1'b0;

        unique case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                // ack is only honoured while the request is out
                if (imem_ack) begin
                    w_inst_nxt  = imem_rdata;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                reg_en      = w_write_class;
                w_state_nxt = S_FETCH;
                case (w_opcode)
                    OP_JMP:  w_pc_nxt = w_imm;
                    OP_BZ:   w_pc_nxt = zero_flag ? w_imm : w_pc_inc;
                    OP_HALT: w_state_nxt = S_HALT;
                    default: w_pc_nxt = w_pc_inc;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase

        // reset masks every externally visible strobe in the same cycle
        if (rst) begin
            imem_req = 1'b0;
            reg_en   = 1'b0;
            halted   = 1'b0;
        end
    end

    assign imem_addr = r_pc;
    assign inst      = r_inst;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected fetch addresses and
// EXEC-cycle results; a negedge monitor pops and compares them as the DUT presents them.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic        zero_flag;
    logic [15:0] inst;
    logic        reg_en;
    logic        halted;

    int checks;
    int errors;

    logic [7:0]  q_addr[$];
    logic [16:0] q_exec[$];
    logic        exec_pending;
    logic [15:0] last_inst;

    fetch_ctrl #(.RESET_PC(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_rdata(imem_rdata),
        .imem_ack  (imem_ack),
        .zero_flag (zero_flag),
        .inst      (inst),
        .reg_en    (reg_en),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: an accepted fetch (req & ack) consumes one address entry; the
    // following cycle is EXEC and consumes one {inst, reg_en} entry.
    initial exec_pending = 1'b0;
    always @(negedge clk) begin
        logic [16:0] e;
        logic [7:0]  a;
        if (exec_pending) begin
            if (q_exec.size() == 0) begin
                check("exec_queue_underflow", 32'd0, 32'd1);
            end else begin
                e = q_exec.pop_front();
                check("exec_inst", {16'h0, inst}, {16'h0, e[16:1]});
                check("exec_reg_en", {31'h0, reg_en}, {31'h0, e[0]});
            end
        end
        exec_pending = imem_req && imem_ack;
        if (imem_req && imem_ack) begin
            if (q_addr.size() == 0) begin
                check("addr_queue_underflow", 32'd0, 32'd1);
            end else begin
                a = q_addr.pop_front();
                check("fetch_addr", {24'h0, imem_addr}, {24'h0, a});
            end
        end
    end

    // Entered just after a rising edge with the DUT in FETCH; returns just after
    // the edge that ends EXEC.
    task automatic do_fetch(input logic [15:0] w, input int waits, input logic [7:0] a,
                            input logic exp_we, input logic zf, input logic rst_exec);
        q_addr.push_back(a);
        q_exec.push_back({w, exp_we});
        zero_flag = zf;
        for (int i = 0; i < waits; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = 16'hDEAD;
            @(negedge clk);
            check("wait_req", {31'h0, imem_req}, 32'd1);
            check("wait_addr", {24'h0, imem_addr}, {24'h0, a});
            check("wait_inst", {16'h0, inst}, {16'h0, last_inst});
            check("wait_reg_en", {31'h0, reg_en}, 32'd0);
            @(posedge clk); #1;
        end
        imem_ack   = 1'b1;
        imem_rdata = w;
        #1;
        check("ack_cycle_req", {31'h0, imem_req}, 32'd1);
        @(posedge clk); #1;
        // EXEC cycle: a stray ack with junk data must be ignored
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        rst        = rst_exec;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        rst        = 1'b0;
        last_inst  = rst_exec ? 16'h0000 : w;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'h5555;
        zero_flag  = 1'b0;
        last_inst  = 16'h0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'h0, imem_req}, 32'd0);
        check("rst_halted", {31'h0, halted}, 32'd0);
        check("rst_reg_en", {31'h0, reg_en}, 32'd0);
        check("rst_addr", {24'h0, imem_addr}, 32'h00);
        check("rst_inst", {16'h0, inst}, 32'h0000);
        @(posedge clk); #1;
        rst      = 1'b0;
        imem_ack = 1'b0;

        do_fetch(16'h1405, 0, 8'h00, 1'b1, 1'b0, 1'b0);  // LDI R1,5
        do_fetch(16'h3011, 3, 8'h01, 1'b1, 1'b0, 1'b0);  // 3 wait states
        do_fetch(16'h9020, 0, 8'h02, 1'b0, 1'b1, 1'b0);  // BZ taken
        do_fetch(16'h9020, 0, 8'h20, 1'b0, 1'b0, 1'b0);  // BZ not taken
        do_fetch(16'h80FF, 0, 8'h21, 1'b0, 1'b0, 1'b0);  // JMP FF
        do_fetch(16'h0000, 0, 8'hFF, 1'b0, 1'b0, 1'b0);  // NOP wraps PC
        do_fetch(16'h2600, 0, 8'h00, 1'b0, 1'b0, 1'b1);  // ADD aborted by rst

        @(negedge clk);
        check("abort_addr", {24'h0, imem_addr}, 32'h00);
        check("abort_inst", {16'h0, inst}, 32'h0000);
        check("abort_req", {31'h0, imem_req}, 32'd1);
        @(posedge clk); #1;

        do_fetch(16'hA105, 0, 8'h00, 1'b0, 1'b0, 1'b0);  // NOP-class opcode A
        do_fetch(16'h7123, 0, 8'h01, 1'b1, 1'b0, 1'b0);  // write-class upper bound
        do_fetch(16'h9002, 1, 8'h02, 1'b0, 1'b1, 1'b0);  // BZ to own address
        do_fetch(16'hF000, 0, 8'h02, 1'b0, 1'b0, 1'b0);  // HALT

        for (int i = 0; i < 10; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = 16'h1111;
            @(negedge clk);
            check("halt_halted", {31'h0, halted}, 32'd1);
            check("halt_req", {31'h0, imem_req}, 32'd0);
            check("halt_addr", {24'h0, imem_addr}, 32'h02);
            check("halt_inst", {16'h0, inst}, 32'hF000);
            @(posedge clk); #1;
        end

        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'h1234;
        @(negedge clk);
        check("halt_rst_halted", {31'h0, halted}, 32'd0);
        check("halt_rst_req", {31'h0, imem_req}, 32'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        check("post_rst_addr", {24'h0, imem_addr}, 32'h00);
        check("post_rst_halted", {31'h0, halted}, 32'd0);
        check("post_rst_req", {31'h0, imem_req}, 32'd1);
        check("post_rst_inst", {16'h0, inst}, 32'h0000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("addr_queue_drained", q_addr.size(), 32'd0);
        check("exec_queue_drained", q_exec.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
